// File: rtl/exec_stage_mc.sv
// Execute stage: K-stage operand forwarding, single-cycle ALU, iterative shift-add MUL/MLA,
// NZCV ownership and ready/valid back-pressure toward decode while a multiply is in flight.
module exec_stage_mc #(
   parameter int WORD               = 32,
   parameter int ADDR_WIDTH         = 4,
   parameter int NUM_OPERANDS       = 3,
   parameter int NUM_FWD_STAGES     = 2,
   parameter int MUL_BITS_PER_CYCLE = 4
) (
   input  logic                               clk_i,
   input  logic                               rst_n_i,
   input  logic                               valid_i,
   output logic                               ready_o,
   input  logic                               flush_i,
   input  logic [2:0]                         op_i,
   input  logic                               update_flag_i,
   input  logic                               b_is_imm_i,
   input  logic [WORD-1:0]                    imm_i,
   input  logic [NUM_OPERANDS*ADDR_WIDTH-1:0] reg_addr_i,
   input  logic [NUM_OPERANDS*WORD-1:0]       reg_data_i,
   input  logic [NUM_FWD_STAGES-1:0]          fwd_we_i,
   input  logic [NUM_FWD_STAGES*ADDR_WIDTH-1:0] fwd_dest_i,
   input  logic [NUM_FWD_STAGES*WORD-1:0]     fwd_data_i,
   input  logic [$clog2(NUM_OPERANDS)-1:0]    store_sel_i,
   output logic [WORD-1:0]                    store_data_o,
   output logic [WORD-1:0]                    result_o,
   output logic                               result_valid_o,
   output logic [3:0]                         flags_o
);

   localparam int MUL_STEPS = WORD / MUL_BITS_PER_CYCLE;
   localparam int CNT_W     = $clog2(MUL_STEPS + 1);

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_ORR = 3'd3;
   localparam logic [2:0] OP_EOR = 3'd4;
   localparam logic [2:0] OP_MOV = 3'd5;
   localparam logic [2:0] OP_MLA = 3'd7;

   typedef enum logic {IDLE, MUL} state_e;

   state_e           state_q;
   logic [WORD-1:0]  result_q;
   logic             resultValid_q;
   logic [3:0]       flags_q;
   logic [WORD-1:0]  mcand_q;
   logic [WORD-1:0]  mplier_q;
   logic [WORD-1:0]  acc_q;
   logic             updFlag_q;
   logic [CNT_W-1:0] cnt_q;

   logic [WORD-1:0]  opnd [NUM_OPERANDS];
   logic [WORD-1:0]  opA;
   logic [WORD-1:0]  opB;
   logic [WORD-1:0]  opC;
   logic [WORD-1:0]  storeData;
   logic [WORD-1:0]  bEff;
   logic [WORD:0]    sumExt;
   logic [WORD-1:0]  aluRes;
   logic             aluC;
   logic             aluV;
   logic [WORD-1:0]  partial;
   logic [WORD-1:0]  mulNext;

   // Oldest stage is applied first so the youngest matching stage overrides it.
   always_comb begin
      for (int j = 0; j < NUM_OPERANDS; j++) begin
         opnd[j] = reg_data_i[j*WORD +: WORD];
         for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
            if (fwd_we_i[k] &&
                fwd_dest_i[k*ADDR_WIDTH +: ADDR_WIDTH] == reg_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH])
               opnd[j] = fwd_data_i[k*WORD +: WORD];
         end
      end
   end

   always_comb begin
      opC       = '0;
      storeData = '0;
      for (int j = 0; j < NUM_OPERANDS; j++) begin
         if (j == 2) opC = opnd[j];
         if (int'(store_sel_i) == j) storeData = opnd[j];
      end
   end

   assign opA          = opnd[0];
   assign opB          = b_is_imm_i ? imm_i : opnd[1];
   assign store_data_o = storeData;

   always_comb begin
      bEff   = (op_i == OP_SUB) ? ~opB : opB;
      sumExt = {1'b0, opA} + {1'b0, bEff} + (WORD+1)'(op_i == OP_SUB);
      aluRes = sumExt[WORD-1:0];
      aluC   = flags_q[1];
      aluV   = flags_q[0];
      case (op_i)
         OP_ADD, OP_SUB: begin
            aluC = sumExt[WORD];
            aluV = (opA[WORD-1] == bEff[WORD-1]) && (sumExt[WORD-1] != opA[WORD-1]);
         end
         OP_AND:  aluRes = opA & opB;
         OP_ORR:  aluRes = opA | opB;
         OP_EOR:  aluRes = opA ^ opB;
         OP_MOV:  aluRes = opB;
         default: aluRes = sumExt[WORD-1:0];
      endcase
   end

   // The accumulator starts at C for MLA, so the final step already holds A*B+C.
   always_comb begin
      partial = '0;
      for (int i = 0; i < MUL_BITS_PER_CYCLE; i++) begin
         if (mplier_q[i]) partial = partial + (mcand_q << i);
      end
      mulNext = acc_q + partial;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q       <= IDLE;
         result_q      <= '0;
         resultValid_q <= 1'b0;
         flags_q       <= '0;
         mcand_q       <= '0;
         mplier_q      <= '0;
         acc_q         <= '0;
         updFlag_q     <= 1'b0;
         cnt_q         <= '0;
      end else begin
         resultValid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (valid_i && !flush_i) begin
                  if (op_i[2:1] == 2'b11) begin
                     mcand_q   <= opA;
                     mplier_q  <= opB;
                     acc_q     <= (op_i == OP_MLA) ? opC : '0;
                     updFlag_q <= update_flag_i;
                     cnt_q     <= CNT_W'(MUL_STEPS - 1);
                     state_q   <= MUL;
                  end else begin
                     result_q      <= aluRes;
                     resultValid_q <= 1'b1;
                     if (update_flag_i)
                        flags_q <= {aluRes[WORD-1], aluRes == '0, aluC, aluV};
                  end
               end
            end
            MUL: begin
               if (flush_i) begin
                  state_q <= IDLE;
               end else begin
                  acc_q    <= mulNext;
                  mcand_q  <= mcand_q << MUL_BITS_PER_CYCLE;
                  mplier_q <= mplier_q >> MUL_BITS_PER_CYCLE;
                  if (cnt_q == '0) begin
                     result_q      <= mulNext;
                     resultValid_q <= 1'b1;
                     if (updFlag_q)
                        flags_q <= {mulNext[WORD-1], mulNext == '0, flags_q[1:0]};
                     state_q <= IDLE;
                  end else begin
                     cnt_q <= cnt_q - 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ready_o        = (state_q == IDLE);
   assign result_o       = result_q;
   assign result_valid_o = resultValid_q;
   assign flags_o        = flags_q;

endmodule

// File: tb/tb_exec_stage_mc.sv
// Self-checking bench for exec_stage_mc: directed scenarios then randomized instructions,
// all compared against an arithmetic reference model of forwarding, ALU, multiply and flags.
module tb_exec_stage_mc;

   localparam longint SMAX = 64'sh7FFFFFFF;
   localparam longint SMIN = -64'sh80000000;

   logic        clk = 1'b0;
   logic        rstN;
   logic        valid;
   logic        ready;
   logic        flush;
   logic [2:0]  op;
   logic        upd;
   logic        bImm;
   logic [31:0] imm;
   logic [11:0] regAddr;
   logic [95:0] regData;
   logic [1:0]  fwdWe;
   logic [7:0]  fwdDest;
   logic [63:0] fwdData;
   logic [1:0]  storeSel;
   logic [31:0] storeData;
   logic [31:0] result;
   logic        resultValid;
   logic [3:0]  flags;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] expResult = '0;
   logic [3:0]  expFlags = '0;

   always #5 clk = ~clk;

   exec_stage_mc dut (
      .clk_i          (clk),
      .rst_n_i        (rstN),
      .valid_i        (valid),
      .ready_o        (ready),
      .flush_i        (flush),
      .op_i           (op),
      .update_flag_i  (upd),
      .b_is_imm_i     (bImm),
      .imm_i          (imm),
      .reg_addr_i     (regAddr),
      .reg_data_i     (regData),
      .fwd_we_i       (fwdWe),
      .fwd_dest_i     (fwdDest),
      .fwd_data_i     (fwdData),
      .store_sel_i    (storeSel),
      .store_data_o   (storeData),
      .result_o       (result),
      .result_valid_o (resultValid),
      .flags_o        (flags)
   );

   // Safety net so the run always terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Youngest matching forwarding stage wins, otherwise the register file value.
   function automatic logic [31:0] resolveOp(input int j);
      for (int k = 0; k < 2; k++) begin
         if (fwdWe[k] && fwdDest[k*4 +: 4] == regAddr[j*4 +: 4]) return fwdData[k*32 +: 32];
      end
      return regData[j*32 +: 32];
   endfunction

   task automatic clearInputs();
      valid    = 1'b0;
      flush    = 1'b0;
      op       = 3'd0;
      upd      = 1'b0;
      bImm     = 1'b0;
      imm      = '0;
      regAddr  = {4'd2, 4'd1, 4'd0};
      regData  = '0;
      fwdWe    = '0;
      fwdDest  = '0;
      fwdData  = '0;
      storeSel = 2'd0;
   endtask

   task automatic setOperand(input int j, input logic [3:0] addr, input logic [31:0] data);
      regAddr[j*4 +: 4]  = addr;
      regData[j*32 +: 32] = data;
   endtask

   task automatic setFwd(input int k, input logic we, input logic [3:0] dest, input logic [31:0] data);
      fwdWe[k]            = we;
      fwdDest[k*4 +: 4]   = dest;
      fwdData[k*32 +: 32] = data;
   endtask

   task automatic applyStimulus(input logic [2:0] o, input logic u, input logic bi, input logic [31:0] im);
      op   = o;
      upd  = u;
      bImm = bi;
      imm  = im;
   endtask

   // Issues the instruction currently on the inputs and checks it through to completion.
   task automatic stepOp(input string tag, input bit busyValid, input int flushAt);
      logic [31:0] a, b, c, r;
      logic        cy, v;
      logic [3:0]  nf;
      longint      sl;
      logic [63:0] prod;
      logic [2:0]  o;
      o  = op;
      a  = resolveOp(0);
      b  = bImm ? imm : resolveOp(1);
      c  = resolveOp(2);
      cy = expFlags[1];
      v  = expFlags[0];
      r  = '0;
      case (o)
         3'd0: begin
            {cy, r} = {1'b0, a} + {1'b0, b};
            sl = longint'($signed(a)) + longint'($signed(b));
            v  = (sl > SMAX) || (sl < SMIN);
         end
         3'd1: begin
            r  = a - b;
            cy = (a >= b);
            sl = longint'($signed(a)) - longint'($signed(b));
            v  = (sl > SMAX) || (sl < SMIN);
         end
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = a ^ b;
         3'd5: r = b;
         3'd6: begin prod = {32'd0, a} * {32'd0, b}; r = prod[31:0]; end
         default: begin prod = {32'd0, a} * {32'd0, b} + {32'd0, c}; r = prod[31:0]; end
      endcase
      nf = upd ? {r[31], (r == 32'd0), cy, v} : expFlags;
      #1;
      checkOutput({tag, ":store"}, storeData, resolveOp(int'(storeSel)));
      checkOutput({tag, ":readyIn"}, ready, 1);
      valid = 1'b1;
      @(negedge clk);
      if (o < 3'd6) begin
         checkOutput({tag, ":valid"}, resultValid, 1);
         checkOutput({tag, ":result"}, result, r);
         checkOutput({tag, ":flags"}, flags, nf);
         valid     = 1'b0;
         expResult = r;
         expFlags  = nf;
      end else begin
         valid = busyValid;
         if (busyValid) op = 3'd0;
         for (int cyc = 1; cyc <= 8; cyc++) begin
            checkOutput({tag, ":busyReady"}, ready, 0);
            checkOutput({tag, ":busyValid"}, resultValid, 0);
            if (cyc == flushAt) begin
               flush = 1'b1;
               @(negedge clk);
               flush = 1'b0;
               valid = 1'b0;
               checkOutput({tag, ":flushValid"}, resultValid, 0);
               checkOutput({tag, ":flushReady"}, ready, 1);
               checkOutput({tag, ":flushFlags"}, flags, expFlags);
               checkOutput({tag, ":flushResult"}, result, expResult);
               return;
            end
            if (cyc == 8) valid = 1'b0;
            @(negedge clk);
         end
         checkOutput({tag, ":mulValid"}, resultValid, 1);
         checkOutput({tag, ":mulReady"}, ready, 1);
         checkOutput({tag, ":mulResult"}, result, r);
         checkOutput({tag, ":mulFlags"}, flags, nf);
         expResult = r;
         expFlags  = nf;
      end
   endtask

   initial begin
      clearInputs();
      rstN = 1'b0;
      #3;
      checkOutput("rstResult", result, 0);
      checkOutput("rstValid", resultValid, 0);
      checkOutput("rstFlags", flags, 0);
      checkOutput("rstReady", ready, 1);
      @(negedge clk);
      rstN = 1'b1;

      setOperand(0, 4'd3, 32'h33);
      setFwd(0, 1'b1, 4'd3, 32'h11);
      setFwd(1, 1'b1, 4'd3, 32'h22);
      applyStimulus(3'd0, 1'b0, 1'b1, 32'd1);
      stepOp("fwdMem", 0, 0);
      checkOutput("fwdMemConst", result, 32'h12);
      setFwd(0, 1'b0, 4'd3, 32'h11);
      stepOp("fwdWb", 0, 0);
      checkOutput("fwdWbConst", result, 32'h23);
      setFwd(1, 1'b0, 4'd3, 32'h22);
      stepOp("fwdReg", 0, 0);
      checkOutput("fwdRegConst", result, 32'h34);

      clearInputs();
      setOperand(0, 4'd1, 32'h5);
      setOperand(1, 4'd2, 32'h5);
      applyStimulus(3'd1, 1'b1, 1'b0, '0);
      stepOp("subZero", 0, 0);
      checkOutput("subZeroNZCV", flags, 4'b0110);
      setOperand(0, 4'd1, 32'h7FFFFFFF);
      setOperand(1, 4'd2, 32'h1);
      applyStimulus(3'd0, 1'b1, 1'b0, '0);
      stepOp("addOvf", 0, 0);
      checkOutput("addOvfNZCV", flags, 4'b1001);
      setOperand(0, 4'd1, 32'h0);
      setOperand(1, 4'd2, 32'h0);
      applyStimulus(3'd3, 1'b1, 1'b0, '0);
      stepOp("orrZero", 0, 0);
      checkOutput("orrNZCV", flags, 4'b0101);

      setOperand(0, 4'd1, 32'h1234);
      setOperand(1, 4'd2, 32'h10);
      setOperand(2, 4'd5, 32'h5);
      applyStimulus(3'd7, 1'b0, 1'b0, '0);
      stepOp("mla", 1, 0);
      checkOutput("mlaConst", result, 32'h12345);
      @(negedge clk);
      checkOutput("mlaNoExtra", resultValid, 0);

      setOperand(0, 4'd1, 32'hFFFFFFFF);
      setOperand(1, 4'd2, 32'hFFFFFFFF);
      applyStimulus(3'd6, 1'b1, 1'b0, '0);
      stepOp("mulWrap", 0, 0);
      checkOutput("mulWrapConst", result, 32'h1);
      checkOutput("mulWrapNZCV", flags, 4'b0001);

      setOperand(0, 4'd1, 32'h3);
      setOperand(1, 4'd2, 32'h4);
      applyStimulus(3'd6, 1'b1, 1'b0, '0);
      stepOp("mulFlush", 0, 4);
      applyStimulus(3'd0, 1'b1, 1'b0, '0);
      stepOp("addAfterFlush", 0, 0);
      checkOutput("addAfterFlushConst", result, 32'h7);

      applyStimulus(3'd5, 1'b1, 1'b0, '0);
      valid = 1'b1;
      flush = 1'b1;
      @(negedge clk);
      checkOutput("idleFlushValid", resultValid, 0);
      checkOutput("idleFlushFlags", flags, expFlags);
      flush = 1'b0;
      valid = 1'b0;

      setOperand(0, 4'd1, 32'h9);
      setOperand(1, 4'd2, 32'h9);
      applyStimulus(3'd6, 1'b0, 1'b0, '0);
      #1 valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1 rstN = 1'b0;
      #1;
      checkOutput("midRstResult", result, 0);
      checkOutput("midRstValid", resultValid, 0);
      checkOutput("midRstFlags", flags, 0);
      checkOutput("midRstReady", ready, 1);
      @(negedge clk);
      rstN      = 1'b1;
      expResult = '0;
      expFlags  = '0;

      clearInputs();
      for (int i = 0; i < 3; i++) begin
         setOperand(0, 4'd1, 32'(i + 1));
         setOperand(1, 4'd2, 32'h100);
         applyStimulus(3'd0, 1'b1, 1'b0, '0);
         stepOp("b2bAdd", 0, 0);
      end

      for (int i = 0; i < 30; i++) begin
         for (int j = 0; j < 3; j++) setOperand(j, 4'($urandom_range(0, 3)), $urandom);
         for (int k = 0; k < 2; k++) setFwd(k, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), $urandom);
         storeSel = 2'($urandom_range(0, 2));
         applyStimulus(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), $urandom);
         stepOp("rand", 0, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/exec_stage_mc.md
Name: exec_stage_mc

Overview:
Parametrised execute stage and the next generation of the single-cycle execute datapath. It resolves N source operands through a generic K-stage forwarding network (youngest stage wins) and executes single-cycle ALU ops plus a multi-cycle iterative multiply / multiply-accumulate. It owns the NZCV status register and back-pressures decode with a ready/valid handshake while a multiply is in flight. It sits between the decode pipeline register and the MEM pipeline register.

Parameters:
WORD, 32, datapath width in bits
ADDR_WIDTH, 4, register address width
NUM_OPERANDS, 3, source operands per instruction (min 2; operand 0 = A, 1 = B, 2 = accumulate)
NUM_FWD_STAGES, 2, forwarding sources; index 0 = youngest (MEM), ascending = older (WB, ...)
MUL_BITS_PER_CYCLE, 4, multiplier bits retired per cycle; must divide WORD

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
valid_i  in  1  decode presents an instruction
ready_o  out  1  stage can accept; valid_i && ready_o = accept
flush_i  in  1  squash in-flight operation
op_i  in  3  0 ADD, 1 SUB, 2 AND, 3 ORR, 4 EOR, 5 MOV(B), 6 MUL(A*B), 7 MLA(A*B+C)
update_flag_i  in  1  write NZCV on completion
b_is_imm_i  in  1  operand B = imm_i instead of register
imm_i  in  WORD  immediate
reg_addr_i  in  NUM_OPERANDS*ADDR_WIDTH  source addresses, operand j at [j*ADDR_WIDTH +: ADDR_WIDTH]
reg_data_i  in  NUM_OPERANDS*WORD  register-file read data
fwd_we_i  in  NUM_FWD_STAGES  forwarding-stage write enables
fwd_dest_i  in  NUM_FWD_STAGES*ADDR_WIDTH  forwarding-stage destinations
fwd_data_i  in  NUM_FWD_STAGES*WORD  forwarding-stage data
store_sel_i  in  $clog2(NUM_OPERANDS)  operand routed to store_data_o
store_data_o  out  WORD  forwarded operand for memory stores (combinational)
result_o  out  WORD  registered result
result_valid_o  out  1  one-cycle pulse; result_o is valid
flags_o  out  4  NZCV {N,Z,C,V}, registered

Behaviour:
- Reset (async assert, sync release): state IDLE, result_o=0, result_valid_o=0, flags_o=0, ready_o=1, multiplier datapath cleared.
- Forwarding, per operand j: use the lowest stage k with fwd_we_i[k] && fwd_dest_i[k]==addr_j, giving fwd_data_i[k]; if no stage matches, use reg_data_i[j]. This logic is purely combinational and applies every cycle. store_data_o = resolved operand store_sel_i, independent of state.
- States:
  - IDLE: ready_o=1. Accept of op 0–5 computes in the same cycle and registers the result, giving result_valid_o=1 on the next cycle (latency 1). Back-to-back accepts give one result per cycle. Accept of op 6/7 captures the resolved A, B, C, op and update flag, then moves to MUL.
  - MUL: ready_o=0. Each cycle retires MUL_BITS_PER_CYCLE bits of B (LSB first, shift-add, low WORD bits kept). After WORD/MUL_BITS_PER_CYCLE cycles, result_o = product (+C for MLA, modulo 2^WORD), result_valid_o pulses, and the state returns to IDLE. Accept-to-result latency is WORD/MUL_BITS_PER_CYCLE+1 cycles (9 by default). ready_o returns to 1 in the cycle result_valid_o is asserted.
- Flags: written only when update_flag_i was set at accept, in the same edge that result_o is written. N=result[WORD-1], Z=(result==0). ADD/SUB: C = carry-out (SUB: C=1 means no borrow, computed as A+~B+1), V = signed overflow. Ops 2–7 leave C and V unchanged.
- flush_i: highest priority. In IDLE, no accept occurs even if valid_i=1, and any result registered on that edge is suppressed (result_valid_o=0). In MUL, the stage returns to IDLE next cycle with no result_valid_o, no flag write, and result_o retained.
- Reset asserted mid-multiply: immediate return to reset values; the operation is lost.
- valid_i while ready_o=0: ignored. Decode must hold its inputs.

Test Plan:
- Forward priority: operand A addr 3; MEM writes 3 with 0x11, WB writes 3 with 0x22, regfile 0x33; ADD with B=imm 1 -> result 0x12 next cycle. Drop MEM -> 0x23. Drop both -> 0x34.
- Flags: SUB 0x5-0x5 with update -> result 0, NZCV=0110. ADD 0x7FFFFFFF+1 -> 0x80000000, NZCV=1001. ORR 0 with update afterwards -> NZCV=0101 (C, V held).
- MLA 0x1234*0x10+0x5 -> ready_o low 8 cycles, result_valid_o on cycle 9 with 0x12345. valid_i during busy ignored.
- MUL wrap: 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001. With update, N=0, Z=0.
- Flush at MUL cycle 4 -> no result_valid_o, flags unchanged, ready_o=1 next cycle. A following ADD completes normally.
- Async reset pulse mid-MUL without a clock edge -> outputs at reset values immediately. Back-to-back ADDs after release -> one result_valid_o per cycle.
